cla_word_serial_adder: RTL and testbench

- Word-serial wide-operand adder stage. Accepts operands as a stream of 16-bit beats over a valid/ready handshake, least-significant word first.
- Drives one internal look_ahead16bit instance (ports a, b, cin, s, cout) with the registered carry chained between beats.
- Returns one registered 16-bit sum word per beat to a downstream consumer.
- Sits directly upstream of look_ahead16bit, sequencing it to build adds of up to MAX_WORDS*16 bits.

---
 rtl/cla_word_serial_adder.sv | 197 +++++++++++++++++++
 tb/tb_cla_word_serial_adder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_serial_adder.sv
// rtl/cla_word_serial_adder.sv - word-serial wide adder sequencing a 16-bit carry-lookahead core
// Optional stat_ops/stat_errs counters are built when CLA_SEQ_STATS_EN is defined.

module look_ahead16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [15:0] w_c;
  logic [3:0]  w_gp;
  logic [3:0]  w_gg;
  logic [4:0]  w_gc;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Four 4-bit groups; each resolves its internal carries from the group carry-in.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;

    assign w_gp[k] = &w_p[B+3:B];
    assign w_gg[k] = w_g[B+3]
                   | (w_p[B+3] & w_g[B+2])
                   | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                   | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);

    assign w_c[B]   = w_gc[k];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
    assign w_c[B+2] = w_g[B+1]
                    | (w_p[B+1] & w_g[B])
                    | (w_p[B+1] & w_p[B] & w_gc[k]);
    assign w_c[B+3] = w_g[B+2]
                    | (w_p[B+2] & w_g[B+1])
                    | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
  end

  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_gc[2] = w_gg[1]
                 | (w_gp[1] & w_gg[0])
                 | (w_gp[1] & w_gp[0] & cin);
  assign w_gc[3] = w_gg[2]
                 | (w_gp[2] & w_gg[1])
                 | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign w_gc[4] = w_gg[3]
                 | (w_gp[3] & w_gg[2])
                 | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

  assign s    = w_p ^ w_c;
  assign cout = w_gc[4];

endmodule

module cla_word_serial_adder #(
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_cin,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_cout,
  output logic        out_last,
  output logic        out_ovf,
  output logic        out_err,
`ifdef CLA_SEQ_STATS_EN
  output logic        busy,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_errs
`else
  output logic        busy
`endif
);

  localparam int CW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  if (MAX_WORDS < 1 || CNT_W < 1) begin : g_param_check
    $error("cla_word_serial_adder: MAX_WORDS and CNT_W must be positive");
  end

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_CHAIN = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic [15:0]     r_sum;
  logic            r_cout;
  logic            r_last;
  logic            r_ovf;
  logic            r_err;

  logic [15:0]     w_s;
  logic            w_cout;
  logic            w_cin;
  logic            w_accept;
  logic            w_consume;
  logic            w_term;
  logic            w_forced;
  logic            w_ovf;

  look_ahead16bit u_cla (
    .a    (in_a),
    .b    (in_b),
    .cin  (w_cin),
    .s    (w_s),
    .cout (w_cout)
  );

  // Only the least-significant word takes the external carry; later words chain.
  assign w_cin     = (r_state == ST_FIRST) ? in_cin : r_carry;
  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_valid && out_ready;
  assign w_term    = in_last || (r_cnt == LAST_IDX);
  assign w_forced  = w_term && !in_last;
  assign w_ovf     = w_term && (in_a[15] == in_b[15]) && (w_s[15] != in_a[15]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FIRST;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_sum   <= w_s;
      r_cout  <= w_cout;
      r_last  <= w_term;
      r_ovf   <= w_ovf;
      r_err   <= w_forced;
      if (w_term) begin
        r_state <= ST_FIRST;
        r_carry <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_state <= ST_CHAIN;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CW'(1);
      end
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_last  = r_last;
  assign out_ovf   = r_ovf;
  assign out_err   = r_err;
  assign busy      = (r_state == ST_CHAIN);

`ifdef CLA_SEQ_STATS_EN
  logic [CNT_W-1:0] r_stat_ops;
  logic [CNT_W-1:0] r_stat_errs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ops  <= '0;
      r_stat_errs <= '0;
    end else if (w_accept) begin
      if (w_term)   r_stat_ops  <= r_stat_ops + CNT_W'(1);
      if (w_forced) r_stat_errs <= r_stat_errs + CNT_W'(1);
    end
  end

  assign stat_ops  = r_stat_ops;
  assign stat_errs = r_stat_errs;
`endif

endmodule

// File: tb/tb_cla_word_serial_adder.sv
// tb/tb_cla_word_serial_adder.sv - randomized bench for cla_word_serial_adder with a wide-integer reference model
// Stat counters are checked only when CLA_SEQ_STATS_EN is defined.

module tb_cla_word_serial_adder;

  localparam int MAX_WORDS = 4;
  localparam int CNT_W     = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_last;
  logic        out_ovf;
  logic        out_err;
  logic        busy;
`ifdef CLA_SEQ_STATS_EN
  logic [CNT_W-1:0] stat_ops;
  logic [CNT_W-1:0] stat_errs;
`endif

  cla_word_serial_adder #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_last  (out_last),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
`ifdef CLA_SEQ_STATS_EN
    .busy      (busy),
    .stat_ops  (stat_ops),
    .stat_errs (stat_errs)
`else
    .busy      (busy)
`endif
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        last;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks;
  int          n_pass;
  bit          rand_rdy;
  bit          mon_en;
  int          last_wait;
  bit          hold_pend;
  logic [31:0] hold_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Whole-operand reference: add the wide integers, then slice out each word and the carry across it.
  task automatic expect_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                           input int n, input bit forced);
    logic [79:0] tot;
    logic [79:0] part;
    logic [79:0] msk;
    exp_t        e;
    tot = {16'b0, a} + {16'b0, b} + 80'(cin);
    for (int k = 0; k < n; k++) begin
      msk    = (80'(1) << (16 * (k + 1))) - 80'(1);
      part   = ({16'b0, a} & msk) + ({16'b0, b} & msk) + 80'(cin);
      e.sum  = tot[16*k +: 16];
      e.cout = part[16*(k+1)];
      e.last = (k == n - 1);
      e.err  = forced && (k == n - 1);
      e.ovf  = (k == n - 1) && (a[16*n-1] == b[16*n-1]) && (tot[16*n-1] != a[16*n-1]);
      exp_q.push_back(e);
    end
  endtask

  task automatic next_ready();
    if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic last);
    bit done;
    done     = 0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_last  = last;
    in_valid = 1'b1;
    last_wait = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else last_wait++;
      sync();
      next_ready();
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input int n, input bit forced);
    expect_op(a, b, cin, n, forced);
    for (int k = 0; k < n; k++)
      send_beat(a[16*k +: 16], b[16*k +: 16], (k == 0) ? cin : 1'($urandom_range(0, 1)),
                (k == n - 1) && !forced);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_pend)
        chk("hold_stable", {11'b0, out_valid, out_sum, out_cout, out_last, out_ovf, out_err}, hold_val);
      hold_pend = 0;
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat", {11'b0, out_sum, out_cout, out_last, out_ovf, out_err}, {11'b0, e});
        end
      end else if (out_valid && !rst) begin
        hold_pend = 1;
        hold_val  = {11'b0, out_valid, out_sum, out_cout, out_last, out_ovf, out_err};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] x, y;
    logic [63:0] ra, rb;
    int          n;
    bit          forced;
    n_checks = 0;
    n_pass   = 0;
    rand_rdy = 0;
    mon_en   = 0;
    hold_pend = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_outs", {27'b0, out_cout, out_last, out_ovf, out_err, busy}, 0);
    chk("rst_sum", 32'(out_sum), 0);
    chk("rst_ready", 32'(in_ready), 1);
    sync();
    rst    = 1'b0;
    mon_en = 1;

    // Single word with carry-in
    send_op(64'd2, 64'd2, 1'b1, 1, 0);
    @(negedge clk);
    chk("t1_sum", {16'b0, out_sum}, 5);
    chk("t1_flags", {28'b0, out_cout, out_last, out_ovf, out_err}, 4'b0100);
    sync();

    // Two-word carry chain
    expect_op(64'h0000_FFFF, 64'h0000_0001, 1'b0, 2, 0);
    send_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_b0", {15'b0, out_sum, out_cout}, 1);
    chk("t2_busy0", 32'(busy), 1);
    sync();
    send_beat(16'h0000, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_b1", {14'b0, out_sum, out_cout, out_last}, {14'b0, 16'd1, 1'b0, 1'b1});
    chk("t2_busy1", 32'(busy), 0);
    sync();

    // Signed overflow
    send_op(64'h7FFF, 64'h0001, 1'b0, 1, 0);
    @(negedge clk);
    chk("t3_sum", {16'b0, out_sum}, 32'h8000);
    chk("t3_ovf_cout", {30'b0, out_ovf, out_cout}, 2);
    sync();

    // Forced termination at MAX_WORDS, then a fresh FIRST beat
    expect_op(64'h0001_0001_0001_0001, 64'h0, 1'b0, 4, 1);
    for (int k = 0; k < 4; k++) send_beat(16'd1, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_last_err", {30'b0, out_last, out_err}, 3);
    sync();
    send_op(64'd0, 64'd0, 1'b1, 1, 0);
    @(negedge clk);
    chk("t4_first", {15'b0, out_sum, out_err}, 2);
    sync();

    // Backpressure
    sync();
    x = 16'($urandom);
    y = 16'($urandom);
    expect_op({48'b0, x}, {48'b0, y}, 1'b0, 1, 0);
    out_ready = 1'b0;
    send_beat(x, y, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_ready", 32'(in_ready), 0);
      chk("t5_sum", {16'b0, out_sum}, {16'b0, 16'(x + y)});
      sync();
    end
    out_ready = 1'b1;
    x = 16'($urandom);
    y = 16'($urandom);
    send_op({48'b0, x}, {48'b0, y}, 1'b0, 1, 0);
    chk("t5_same_cycle", last_wait, 0);
    sync();

    // Reset mid-operand drops the partial result and its carry
    exp_q.push_back('{sum: 16'h0, cout: 1'b1, last: 1'b0, ovf: 1'b0, err: 1'b0});
    send_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy_pre", 32'(busy), 1);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after_rst", {30'b0, out_valid, busy}, 0);
    sync();
    send_op(64'd0, 64'd0, 1'b0, 1, 0);
    @(negedge clk);
    chk("t6_sum", {15'b0, out_sum, out_cout}, 0);
`ifdef CLA_SEQ_STATS_EN
    chk("t6_stat_ops", 32'(stat_ops), 1);
    chk("t6_stat_errs", 32'(stat_errs), 0);
`endif
    sync();

    // Randomized operands with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      n      = $urandom_range(1, MAX_WORDS);
      forced = (n == MAX_WORDS) && ($urandom_range(0, 3) == 0);
      ra     = {$urandom, $urandom};
      rb     = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) rb = ~ra;
      if (n < 4) begin
        ra = ra & ((64'd1 << (16 * n)) - 64'd1);
        rb = rb & ((64'd1 << (16 * n)) - 64'd1);
      end
      send_op(ra, rb, 1'($urandom_range(0, 1)), n, forced);
      if ($urandom_range(0, 5) == 0) begin
        sync();
        next_ready();
      end
    end

    rand_rdy  = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) sync();
    chk("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
